// File: rtl/btn_debounce.sv
// Four-channel push-button debouncer with optional auto-repeat.
// Latency: a new stable BTN_RAW level appears on BTN_LEVEL STABLE_CNT+2 clocks after it is first sampled.
// Backpressure: none; outputs are free-running pulses and levels, and nothing upstream can be stalled.
//
// Ports:
//   CLK          single clock, all state updates on the rising edge
//   RST          synchronous active-high reset
//   BTN_RAW      raw asynchronous buttons {BTND, BTNU, BTNR, BTNL}
//   BTN_LEVEL    debounced level per button
//   BTN_PRESS    one-clock pulse per accepted press (and per auto-repeat when enabled)
//   BTN_RELEASE  one-clock pulse per accepted release
//
// Optional feature: define BTN_DEBOUNCE_AUTOREPEAT_EN to add a per-channel
// repeat timer. The timer re-pulses BTN_PRESS while a button is held.
// Without the macro, REPEAT_DLY and REPEAT_RATE are only range-checked.
module btn_debounce #(
  parameter int unsigned STABLE_CNT  = 1000000,
  parameter int unsigned REPEAT_DLY  = 50000000,
  parameter int unsigned REPEAT_RATE = 10000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BTN_RAW,
  output logic [3:0] BTN_LEVEL,
  output logic [3:0] BTN_PRESS,
  output logic [3:0] BTN_RELEASE
);

  // The counter only ever reaches STABLE_CNT-1. It clears on the terminal count.
  localparam int unsigned   CW       = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } st_t;

  // Elaboration-time range checks on the configuration.
  if (STABLE_CNT < 32'd1 || STABLE_CNT > 32'd16777215) begin : g_bad_stable_cnt
    $error("btn_debounce: STABLE_CNT must be in 1..2^24-1");
  end
  if (REPEAT_DLY < 32'd1 || REPEAT_DLY > 32'd268435455) begin : g_bad_repeat_dly
    $error("btn_debounce: REPEAT_DLY must be in 1..2^28-1");
  end
  if (REPEAT_RATE < 32'd1 || REPEAT_RATE > 32'd268435455) begin : g_bad_repeat_rate
    $error("btn_debounce: REPEAT_RATE must be in 1..2^28-1");
  end

  // Two-flop synchronizer. BTN_RAW is asynchronous, and nothing else may look at it.
  logic [3:0] s1;
  logic [3:0] s2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1 <= 4'b0000;
      s2 <= 4'b0000;
    end else begin
      s1 <= BTN_RAW;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    st_t           st;
    logic [CW-1:0] cnt;
    logic          lvl_q;
    logic          prs_q;
    logic          rel_q;
    logic          differ;

    // The synchronized input disagrees with the currently accepted level.
    assign differ = s2[i] ^ lvl_q;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [27:0] DLY_LAST  = 28'(REPEAT_DLY - 1);
    localparam logic [27:0] RATE_LAST = 28'(REPEAT_RATE - 1);

    logic [27:0] rpt_tmr;
    // Set until the first repeat pulse is issued. Selects the initial delay
    // over the steady repeat rate.
    logic        rpt_first;
`endif

    always_ff @(posedge CLK) begin
      if (RST) begin
        st    <= IDLE_LO;
        cnt   <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        rpt_tmr   <= '0;
        rpt_first <= 1'b1;
`endif
      end else begin
        prs_q <= 1'b0;
        rel_q <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        // The timer only runs while sitting in IDLE_HI with the button still
        // held. Any other path through the FSM restarts it from scratch.
        rpt_tmr   <= '0;
        rpt_first <= 1'b1;
`endif
        case (st)
          IDLE_LO, IDLE_HI: begin
            if (differ) begin
              // The IDLE counter is 0. With STABLE_CNT=1 this first
              // differing sample is already the terminal one.
              if (cnt == CNT_LAST) begin
                st    <= lvl_q ? IDLE_LO : IDLE_HI;
                lvl_q <= ~lvl_q;
                prs_q <= ~lvl_q;
                rel_q <= lvl_q;
                cnt   <= '0;
              end else begin
                st  <= lvl_q ? WAIT_LO : WAIT_HI;
                cnt <= cnt + CW'(1);
              end
            end else begin
              cnt <= '0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
              if (st == IDLE_HI) begin
                if (rpt_tmr == (rpt_first ? DLY_LAST : RATE_LAST)) begin
                  prs_q     <= 1'b1;
                  rpt_tmr   <= '0;
                  rpt_first <= 1'b0;
                end else begin
                  rpt_tmr   <= rpt_tmr + 28'd1;
                  rpt_first <= rpt_first;
                end
              end
`endif
            end
          end

          WAIT_HI, WAIT_LO: begin
            if (!differ) begin
              // A glitch returned to the accepted level. Drop it silently.
              st  <= lvl_q ? IDLE_HI : IDLE_LO;
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              st    <= lvl_q ? IDLE_LO : IDLE_HI;
              lvl_q <= ~lvl_q;
              prs_q <= ~lvl_q;
              rel_q <= lvl_q;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end

          default: begin
            st  <= IDLE_LO;
            cnt <= '0;
          end
        endcase
      end
    end

    assign BTN_LEVEL[i]   = lvl_q;
    assign BTN_PRESS[i]   = prs_q;
    assign BTN_RELEASE[i] = rel_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce. Directed scenarios with literal
// expectations are followed by a long randomized run. A window-based
// behavioural model is compared against the DUT on every cycle.
module tb_btn_debounce;

  localparam int SC = 4;
  localparam int RD = 8;
  localparam int RR = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] BTN_RAW = 4'b0000;
  logic [3:0] BTN_LEVEL;
  logic [3:0] BTN_PRESS;
  logic [3:0] BTN_RELEASE;

  int checks   = 0;
  int failures = 0;

  btn_debounce #(
    .STABLE_CNT (SC),
    .REPEAT_DLY (RD),
    .REPEAT_RATE(RR)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN_RAW    (BTN_RAW),
    .BTN_LEVEL  (BTN_LEVEL),
    .BTN_PRESS  (BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // Raw input is delayed two samples. The level flips once the last SC
  // delayed samples all disagree with it.
  logic [3:0]    m_s1 = '0;
  logic [3:0]    m_s2 = '0;
  logic [3:0]    m_lvl = '0;
  logic [3:0]    m_prs = '0;
  logic [3:0]    m_rel = '0;
  logic [SC-1:0] m_hist [4];
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  logic [3:0]    m_prev = '0;
  int            m_age [4];
`endif

  task automatic model_step();
    logic [3:0] cur;
    logic [3:0] nl;
    logic [3:0] prs;
    logic [3:0] rel;
    if (RST) begin
      m_s1  = '0;
      m_s2  = '0;
      m_lvl = '0;
      m_prs = '0;
      m_rel = '0;
      for (int i = 0; i < 4; i++) m_hist[i] = '0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      m_prev = '0;
      for (int i = 0; i < 4; i++) m_age[i] = 0;
`endif
    end else begin
      cur  = m_s2;
      m_s2 = m_s1;
      m_s1 = BTN_RAW;
      for (int i = 0; i < 4; i++) begin
        m_hist[i] = {m_hist[i][SC-2:0], cur[i]};
        nl[i]  = m_lvl[i] ? (m_hist[i] != '0) : (m_hist[i] == '1);
        prs[i] = nl[i] & ~m_lvl[i];
        rel[i] = ~nl[i] & m_lvl[i];
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        // age = clocks held high since the press or since a glitch returned
        if (nl[i] && m_lvl[i] && cur[i]) begin
          if (!m_prev[i]) m_age[i] = 0;
          else begin
            m_age[i]++;
            if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RR == 0))
              prs[i] = 1'b1;
          end
        end else begin
          m_age[i] = 0;
        end
`endif
      end
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
      m_prev = cur;
`endif
      m_lvl = nl;
      m_prs = prs;
      m_rel = rel;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    for (int i = 0; i < 4; i++) m_age[i] = 0;
`endif
    forever begin
      @(posedge CLK);
      model_step();
    end
  end

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  // Continuous model comparison on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      cmp("model_level", BTN_LEVEL, m_lvl);
      cmp("model_press", BTN_PRESS, m_prs);
      cmp("model_release", BTN_RELEASE, m_rel);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Holds reset for a few clocks and checks the reset state. It then releases
  // reset with BTN_RAW = raw, so the next rising edge is edge 1.
  task automatic start(input logic [3:0] raw);
    @(negedge CLK);
    RST = 1'b1;
    BTN_RAW = 4'b0000;
    repeat (3) @(negedge CLK);
    cmp("reset_level", BTN_LEVEL, 4'b0000);
    cmp("reset_press", BTN_PRESS, 4'b0000);
    cmp("reset_release", BTN_RELEASE, 4'b0000);
    RST = 1'b0;
    BTN_RAW = raw;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit is_rpt(input int k);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    return k inside {6, 14, 18, 22, 26, 30};
`else
    return k == 6;
`endif
  endfunction

  int hold [4];

  initial begin
    // Single press on bit 0.
    start(4'b0001);
    for (int k = 1; k <= 20; k++) begin
      step();
      cmp("s1_level", BTN_LEVEL, (k >= 6) ? 4'b0001 : 4'b0000);
      cmp("s1_press", BTN_PRESS, (k == 6) ? 4'b0001 : 4'b0000);
      cmp("s1_release", BTN_RELEASE, 4'b0000);
    end

    // Short glitch on bit 2.
    start(4'b0100);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) BTN_RAW = 4'b0000;
      cmp("s2_level", BTN_LEVEL, 4'b0000);
      cmp("s2_press", BTN_PRESS, 4'b0000);
      cmp("s2_release", BTN_RELEASE, 4'b0000);
    end

    // All four rise together, then all four fall together.
    start(4'b1111);
    for (int k = 1; k <= 10; k++) begin
      step();
      cmp("s3_press", BTN_PRESS, (k == 6) ? 4'b1111 : 4'b0000);
    end
    BTN_RAW = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      step();
      cmp("s3_level", BTN_LEVEL, (k >= 6) ? 4'b0000 : 4'b1111);
      cmp("s3_release", BTN_RELEASE, (k == 6) ? 4'b1111 : 4'b0000);
    end

    // Reset during the third wait clock while bit 1 is held.
    start(4'b0010);
    for (int k = 1; k <= 4; k++) begin
      step();
      cmp("s4_pre_level", BTN_LEVEL, 4'b0000);
    end
    RST = 1'b1;
    step();
    cmp("s4_rst_press", BTN_PRESS, 4'b0000);
    cmp("s4_rst_level", BTN_LEVEL, 4'b0000);
    RST = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      cmp("s4_press", BTN_PRESS, (k == 6) ? 4'b0010 : 4'b0000);
    end

    // Bit 3 held for 30 clocks, covering auto-repeat when the feature is enabled.
    start(4'b1000);
    for (int k = 1; k <= 40; k++) begin
      step();
      cmp("s5_press", BTN_PRESS, is_rpt(k) ? 4'b1000 : 4'b0000);
      cmp("s5_release", BTN_RELEASE, (k == 36) ? 4'b1000 : 4'b0000);
      cmp("s5_level", BTN_LEVEL, (k >= 6 && k <= 35) ? 4'b1000 : 4'b0000);
      if (k == 30) BTN_RAW = 4'b0000;
    end

    // Randomized run. Each channel toggles after a random hold, mixing
    // glitches and long holds, with occasional one-clock resets.
    start(4'b0000);
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 10);
    for (int c = 0; c < 4000; c++) begin
      step();
      RST = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 4; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          BTN_RAW[i] = ~BTN_RAW[i];
          case ($urandom_range(0, 3))
            0:       hold[i] = $urandom_range(1, 4);
            1:       hold[i] = $urandom_range(15, 30);
            default: hold[i] = $urandom_range(4, 14);
          endcase
        end
      end
    end
    RST = 1'b0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
